// File: rtl/fft_frame_scheduler.sv
// Ping-pong frame buffer that gathers audio samples into FRAME_LEN frames and
// streams one frame at a time to the FFT Avalon-ST sink.
module fft_frame_scheduler #(
  parameter int FRAME_LEN = 512,
  parameter int DATA_W    = 16,
  parameter int CNT_W     = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_enable,
  input  logic              i_sample_valid,
  input  logic [DATA_W-1:0] i_sample,
  output logic              o_sink_valid,
  input  logic              i_sink_ready,
  output logic              o_sink_sop,
  output logic              o_sink_eop,
  output logic [DATA_W-1:0] o_sink_data,
  input  logic              i_src_eop,
  output logic              o_frame_done,
  output logic              o_busy,
  output logic [CNT_W-1:0]  o_frame_cnt,
  output logic [CNT_W-1:0]  o_drop_cnt,
  output logic              o_overrun
);

  localparam int IDX_W = $clog2(FRAME_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_LOAD     = 2'd1;
  localparam logic [1:0] S_SEND     = 2'd2;
  localparam logic [1:0] S_WAIT_OUT = 2'd3;

  logic [DATA_W-1:0] mem [2*FRAME_LEN];
  logic [DATA_W-1:0] rd_data_p1;

  logic [1:0]       state;
  logic [1:0]       bank_full;
  logic             wr_bank;
  logic [IDX_W-1:0] wr_idx;
  logic             rd_bank;
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] rd_next;

  logic wr_en;
  logic drop;
  logic hs;
  logic eop_hs;
  logic rd_en;

  assign wr_en  = i_sample_valid && !bank_full[wr_bank];
  assign drop   = i_sample_valid &&  bank_full[wr_bank];
  assign hs     = o_sink_valid && i_sink_ready;
  assign eop_hs = hs && (rd_idx == LAST_IDX);

  // Read address runs one beat ahead so the registered RAM output already
  // holds the next beat when the current one is accepted.
  assign rd_next = hs ? rd_idx + 1'b1 : rd_idx;
  assign rd_en   = (state == S_LOAD) || (hs && !eop_hs);

  // ---- stage p0: sample write into the bank selected by the writer
  always_ff @(posedge i_clk) begin
    if (wr_en) mem[{wr_bank, wr_idx}] <= i_sample;
  end

  // ---- stage p1: registered RAM read feeding the sink
  always_ff @(posedge i_clk) begin
    if (rd_en) rd_data_p1 <= mem[{rd_bank, rd_next}];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_bank    <= 1'b0;
      wr_idx     <= '0;
      bank_full  <= 2'b00;
      o_drop_cnt <= '0;
      o_overrun  <= 1'b0;
    end else begin
      if (wr_en) begin
        if (wr_idx == LAST_IDX) begin
          bank_full[wr_bank] <= 1'b1;
          wr_bank            <= ~wr_bank;
          wr_idx             <= '0;
        end else begin
          wr_idx <= wr_idx + 1'b1;
        end
      end
      if (drop) begin
        o_overrun <= 1'b1;
        if (o_drop_cnt != {CNT_W{1'b1}}) o_drop_cnt <= o_drop_cnt + 1'b1;
      end
      // The writer only ever fills an empty bank and the reader only frees a
      // full one, so these two bit updates never target the same bank.
      if (eop_hs) bank_full[rd_bank] <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= S_IDLE;
      rd_bank      <= 1'b0;
      rd_idx       <= '0;
      o_frame_done <= 1'b0;
      o_frame_cnt  <= '0;
    end else begin
      o_frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          rd_idx <= '0;
          if (i_enable && bank_full[rd_bank]) state <= S_LOAD;
        end
        S_LOAD: state <= S_SEND;
        S_SEND: begin
          if (hs) begin
            if (eop_hs) begin
              rd_idx  <= '0;
              rd_bank <= ~rd_bank;
              state   <= S_WAIT_OUT;
            end else begin
              rd_idx <= rd_idx + 1'b1;
            end
          end
        end
        S_WAIT_OUT: begin
          if (i_src_eop) begin
            o_frame_done <= 1'b1;
            o_frame_cnt  <= o_frame_cnt + 1'b1;
            state        <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign o_sink_valid = (state == S_SEND);
  assign o_sink_sop   = o_sink_valid && (rd_idx == '0);
  assign o_sink_eop   = o_sink_valid && (rd_idx == LAST_IDX);
  assign o_sink_data  = o_sink_valid ? rd_data_p1 : '0;
  assign o_busy       = (state != S_IDLE);

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Randomised bench for fft_frame_scheduler: a frame-queue scoreboard predicts
// accepted/dropped samples, the beat stream and the completion counters.
module tb_fft_frame_scheduler;

  localparam int FL = 8;
  localparam int DW = 16;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          sample_valid;
  logic [DW-1:0] sample;
  logic          sink_valid;
  logic          sink_ready;
  logic          sink_sop;
  logic          sink_eop;
  logic [DW-1:0] sink_data;
  logic          src_eop;
  logic          frame_done;
  logic          busy;
  logic [CW-1:0] frame_cnt;
  logic [CW-1:0] drop_cnt;
  logic          overrun;

  always #5 clk = ~clk;

  fft_frame_scheduler #(.FRAME_LEN(FL), .DATA_W(DW), .CNT_W(CW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable),
    .i_sample_valid(sample_valid), .i_sample(sample),
    .o_sink_valid(sink_valid), .i_sink_ready(sink_ready),
    .o_sink_sop(sink_sop), .o_sink_eop(sink_eop), .o_sink_data(sink_data),
    .i_src_eop(src_eop), .o_frame_done(frame_done), .o_busy(busy),
    .o_frame_cnt(frame_cnt), .o_drop_cnt(drop_cnt), .o_overrun(overrun)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Reference model: frames as a sample queue plus counts of buffered frames
  logic [DW-1:0] exp_q[$];
  int  part_cnt, buffered, beat_idx, m_cnt, m_drop;
  bit  m_waiting, m_ovr, m_done, prev_valid;
  int  cyc = 0;
  int  fill_cyc, start_cyc, sop_cyc, eop_cyc, n_valid;

  // Stimulus knobs
  logic [DW-1:0] gen_val;
  int  gen_left = 0, gen_period = 1, gen_phase = 0;
  int  sv_pct = 0, stray_pct = 0, ready_mode = 0, ready_phase = 0;
  int  auto_eop_dly = 0, eop_cd = 0;
  bit  force_eop = 0;

  task automatic model_reset();
    exp_q.delete();
    part_cnt = 0; buffered = 0; beat_idx = 0; m_cnt = 0; m_drop = 0;
    m_waiting = 0; m_ovr = 0; m_done = 0; prev_valid = 0; eop_cd = 0;
  endtask

  task automatic model_cycle();
    bit eop_now;
    eop_now = 0;
    chk("frame_done", 32'(frame_done), 32'(m_done));
    chk("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    if (m_waiting) chk("busy_wait", 32'(busy), 32'd1);
    m_done = 0;
    if (m_waiting && src_eop) begin
      m_done = 1;
      m_cnt = (m_cnt + 1) & 32'hFFFF;
      m_waiting = 0;
    end
    if (sink_valid) begin
      n_valid++;
      if (!prev_valid) start_cyc = cyc;
      chk("valid_allowed", 32'(buffered > 0 && !m_waiting), 32'd1);
      if (exp_q.size() > 0) chk("data", 32'(sink_data), 32'(exp_q[0]));
      chk("sop", 32'(sink_sop), 32'(beat_idx == 0));
      chk("eop", 32'(sink_eop), 32'(beat_idx == FL - 1));
      if (sink_ready && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        if (beat_idx == 0) sop_cyc = cyc;
        beat_idx++;
        if (beat_idx == FL) begin
          beat_idx = 0;
          eop_cyc = cyc;
          eop_now = 1;
        end
      end
    end else begin
      chk("sop_idle", 32'(sink_sop), 32'd0);
      chk("eop_idle", 32'(sink_eop), 32'd0);
    end
    // A bank freed on this edge is still seen as full by a sample on it
    if (sample_valid) begin
      if (part_cnt == 0 && buffered == 2) begin
        if (m_drop < 65535) m_drop++;
        m_ovr = 1;
      end else begin
        exp_q.push_back(sample);
        part_cnt++;
        if (part_cnt == FL) begin
          part_cnt = 0;
          buffered++;
          fill_cyc = cyc;
        end
      end
    end
    if (eop_now) begin
      buffered--;
      m_waiting = 1;
      if (auto_eop_dly > 0) eop_cd = auto_eop_dly;
    end
    prev_valid = sink_valid;
  endtask

  task automatic step();
    sample_valid = 1'b0;
    if (gen_left > 0) begin
      if (gen_phase == 0) begin
        sample_valid = 1'b1;
        sample = gen_val;
        gen_val++;
        gen_left--;
      end
      gen_phase = (gen_phase + 1) % gen_period;
    end else if (sv_pct > 0 && $urandom_range(99) < sv_pct) begin
      sample_valid = 1'b1;
      sample = DW'($urandom);
    end
    case (ready_mode)
      1:       sink_ready = (ready_phase % 3 == 0);
      2:       sink_ready = 1'($urandom_range(1));
      default: sink_ready = 1'b1;
    endcase
    ready_phase++;
    src_eop = 1'b0;
    if (force_eop) begin
      src_eop = 1'b1;
      force_eop = 0;
    end
    if (eop_cd > 0) begin
      eop_cd--;
      if (eop_cd == 0) src_eop = 1'b1;
    end
    if (stray_pct > 0 && $urandom_range(99) < stray_pct) src_eop = 1'b1;
    @(negedge clk);
    cyc++;
    if (!rst_n) model_reset();
    else model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic gen(input int first, input int n, input int period);
    gen_val = DW'(first);
    gen_left = n;
    gen_period = period;
    gen_phase = 0;
  endtask

  task automatic wait_frames(input string tag, input int target, input int budget);
    for (int i = 0; i < budget && m_cnt < target; i++) step();
    chk(tag, 32'(m_cnt >= target), 32'd1);
  endtask

  task automatic wait_sent(input string tag, input int budget);
    for (int i = 0; i < budget && !m_waiting; i++) step();
    chk(tag, 32'(m_waiting), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst_n = 1'b0; enable = 1'b0; sample_valid = 1'b0; sample = '0;
    sink_ready = 1'b0; src_eop = 1'b0;
    model_reset();
    repeat (3) step();
    chk("rst_valid", 32'(sink_valid), 32'd0);
    chk("rst_sop", 32'(sink_sop), 32'd0);
    chk("rst_eop", 32'(sink_eop), 32'd0);
    chk("rst_data", 32'(sink_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    chk("rst_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    rst_n = 1'b1;
    step();

    // Basic frame, ready held high
    enable = 1'b1; ready_mode = 0;
    gen(1, 8, 1);
    wait_sent("t1_sent", 40);
    chk("t1_latency", 32'(start_cyc - fill_cyc), 32'd3);
    chk("t1_burst", 32'(eop_cyc - sop_cyc), 32'(FL - 1));
    repeat (5) step();
    force_eop = 1;
    repeat (2) step();
    chk("t1_cnt", 32'(frame_cnt), 32'd1);

    // Backpressure pattern 1,0,0
    ready_mode = 1; ready_phase = 0;
    gen(1, 8, 1);
    wait_sent("t2_sent", 80);
    force_eop = 1;
    repeat (2) step();
    chk("t2_cnt", 32'(frame_cnt), 32'd2);

    // Fill both banks while disabled, then drain in order
    enable = 1'b0; ready_mode = 0; n_valid = 0;
    gen(0, 24, 1);
    repeat (40) step();
    chk("t3_drop", 32'(drop_cnt), 32'd8);
    chk("t3_ovr", 32'(overrun), 32'd1);
    chk("t3_novalid", 32'(n_valid), 32'd0);
    enable = 1'b1; auto_eop_dly = 20;
    wait_frames("t3_frames", 4, 200);
    step();
    chk("t3_cnt", 32'(frame_cnt), 32'd4);
    auto_eop_dly = 0;

    // Stray src_eop in idle and mid-send is ignored
    force_eop = 1;
    repeat (3) step();
    chk("t4_idle_cnt", 32'(frame_cnt), 32'd4);
    gen(100, 8, 1);
    for (int i = 0; i < 40 && beat_idx != 2; i++) step();
    force_eop = 1;
    wait_sent("t4_sent", 40);
    chk("t4_send_cnt", 32'(frame_cnt), 32'd4);
    force_eop = 1;
    repeat (2) step();
    chk("t4_cnt", 32'(frame_cnt), 32'd5);

    // Continuous stream, 1 sample per 4 cycles, 10 frames
    base = m_cnt;
    auto_eop_dly = 20;
    gen(200, 80, 4);
    wait_frames("t5_frames", base + 10, 700);
    step();
    chk("t5_cnt", 32'(frame_cnt), 32'(base + 10));
    chk("t5_drop", 32'(drop_cnt), 32'd8);

    // Random traffic: backpressure, enable toggles, stray eops
    ready_mode = 2; sv_pct = 30; stray_pct = 2;
    for (int i = 0; i < 3000; i++) begin
      auto_eop_dly = $urandom_range(30, 1);
      if ($urandom_range(49) == 0) enable = ~enable;
      step();
    end
    sv_pct = 0; stray_pct = 0; enable = 1'b1; ready_mode = 0; auto_eop_dly = 5;
    gen(500, (FL - part_cnt) % FL, 1);
    for (int i = 0; i < 800 && (buffered != 0 || m_waiting || gen_left != 0); i++) step();
    chk("t6_drained", 32'(buffered == 0 && !m_waiting), 32'd1);
    auto_eop_dly = 0;

    // Reset mid-frame, then a clean frame
    gen(300, 8, 1);
    for (int i = 0; i < 40 && beat_idx != 3; i++) step();
    chk("t7_beat3", 32'(beat_idx), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("t7_valid", 32'(sink_valid), 32'd0);
    chk("t7_busy", 32'(busy), 32'd0);
    chk("t7_cnt", 32'(frame_cnt), 32'd0);
    chk("t7_drop", 32'(drop_cnt), 32'd0);
    chk("t7_ovr", 32'(overrun), 32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    gen(400, 8, 1);
    wait_sent("t7_sent", 40);
    force_eop = 1;
    repeat (2) step();
    chk("t7_cnt_after", 32'(frame_cnt), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
